// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: program memory, decoder handshake, PC inc/complete control
// Instruction memory is write-anytime, read only in READ; outputs are all registered.
module instr_fetch_unit #(
  parameter int unsigned     ADDR_W  = 6,
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     DEPTH   = 64,
  parameter logic [5:0]      HALT_OP = 6'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] instruction_address,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  output logic              inc,
  output logic              complete
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              inc_q, inc_d;
  logic              complete_q, complete_d;
  logic              is_halt;

  // Non-blocking write and read in the same edge give read-before-write on collision.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign is_halt = (instr_q[DATA_W-1 -: 6] == HALT_OP);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    inc_d      = 1'b0;
    complete_d = complete_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        instr_d = mem_q[instruction_address];
        valid_d = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (is_halt) begin
            complete_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            inc_d   = ~branch;
            state_d = S_ADV;
          end
        end
      end
      S_ADV: begin
        state_d = S_READ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      inc_q      <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      inc_q      <= inc_d;
      complete_q <= complete_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign inc         = inc_q;
  assign complete    = complete_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
// Includes a small PC model that honours inc and a bench-driven load.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT_W = {6'h3F, 26'h0};

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  pc;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        inc;
  logic        complete;
  logic        pc_load;
  logic [5:0]  pc_load_val;

  int          checks = 0;
  int          errors = 0;
  int          inc_cnt = 0;
  logic [31:0] sb [$];

  instr_fetch_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .instruction_address (pc),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data),
    .instr_out           (instr_out),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .branch              (branch),
    .inc                 (inc),
    .complete            (complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)          pc <= 6'd0;
    else if (inc)     pc <= pc + 6'd1;
    else if (pc_load) pc <= pc_load_val;
  end

  always @(posedge clk) begin
    if (inc) inc_cnt <= inc_cnt + 1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick;
    prog_we = 1'b0;
  endtask

  task automatic pulse_en;
    en = 1'b1;
    tick;
    en = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick;
      n++;
    end
    chk(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic check_word(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected a queued word (scoreboard empty)", tag, instr_out);
    end else begin
      chk(tag, instr_out, sb.pop_front());
    end
  endtask

  task automatic accept(input string tag, input logic br);
    check_word(tag);
    instr_ready = 1'b1; branch = br;
    tick;
    instr_ready = 1'b0; branch = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, instr_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_inc"}, {31'd0, inc}, 32'd0);
    chk({tag, "_complete"}, {31'd0, complete}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    int inc_before;
    rst = 1'b1; en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    instr_ready = 1'b0; branch = 1'b0; pc_load = 1'b0; pc_load_val = '0;

    // Reset and idle
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (instr_valid || inc || complete) seen++;
    end
    chk("idle_no_activity", seen, 0);

    // Sequential fetch with backpressure on the second word
    prog(6'd0, 32'h0000_0001);
    prog(6'd1, 32'h0000_0002);
    prog(6'd2, 32'h0000_0003);
    prog(6'd3, HALT_W);
    sb.push_back(32'h0000_0001);
    sb.push_back(32'h0000_0002);
    sb.push_back(32'h0000_0003);
    sb.push_back(HALT_W);

    pulse_en;
    wait_valid("seq1_wait", n);
    chk("seq1_latency", n, 1);
    accept("seq1", 1'b0);
    chk("seq1_inc", {31'd0, inc}, 32'd1);
    wait_valid("seq2_wait", n);
    chk("seq2_period", n, 2);

    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_out", instr_out, 32'h0000_0002);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_inc", {31'd0, inc}, 32'd0);
    end
    inc_before = inc_cnt;
    accept("seq2", 1'b0);
    chk("seq2_inc", {31'd0, inc}, 32'd1);
    wait_valid("seq3_wait", n);
    chk("seq3_period", n, 2);
    chk("bp_one_inc", inc_cnt - inc_before, 1);

    accept("seq3", 1'b0);
    chk("seq3_inc", {31'd0, inc}, 32'd1);
    wait_valid("halt_wait", n);
    accept("halt", 1'b0);
    chk("halt_complete", {31'd0, complete}, 32'd1);
    chk("halt_inc", {31'd0, inc}, 32'd0);
    chk("seq_total_inc", inc_cnt, 3);

    inc_before = inc_cnt;
    en = 1'b1; instr_ready = 1'b1; branch = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    en = 1'b0; instr_ready = 1'b0; branch = 1'b0;
    chk("halt_hold_complete", {31'd0, complete}, 32'd1);
    chk("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_hold_out", instr_out, HALT_W);
    chk("halt_no_inc", inc_cnt - inc_before, 0);

    // Branch: PC loads 10 at the ADV->READ edge
    rst = 1'b1; tick; rst = 1'b0;
    chk_all_zero("rst2");
    prog(6'd0, 32'h0000_0005);
    prog(6'd10, 32'hABCD_0000);
    prog(6'd11, HALT_W);
    sb.push_back(32'h0000_0005);
    sb.push_back(32'hABCD_0000);
    sb.push_back(HALT_W);
    pulse_en;
    wait_valid("br_src_wait", n);
    accept("br_src", 1'b1);
    chk("br_inc", {31'd0, inc}, 32'd0);
    pc_load = 1'b1; pc_load_val = 6'd10;
    tick;
    pc_load = 1'b0;
    wait_valid("br_dst_wait", n);
    accept("br_dst", 1'b0);
    chk("br_dst_inc", {31'd0, inc}, 32'd1);
    wait_valid("br_halt_wait", n);
    accept("br_halt", 1'b0);
    chk("br_halt_complete", {31'd0, complete}, 32'd1);

    // Reset in VALID, then no fetch without a new en
    rst = 1'b1; tick; rst = 1'b0;
    sb.push_back(32'h0000_0005);
    pulse_en;
    wait_valid("mid_wait", n);
    check_word("mid_word");
    rst = 1'b1; tick; rst = 1'b0;
    chk_all_zero("mid_rst");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (instr_valid || inc) seen++;
    end
    chk("mid_no_fetch", seen, 0);

    // Read/write collision at the fetched address
    prog(6'd0, 32'h0000_0011);
    sb.push_back(32'h0000_0011);
    sb.push_back(32'h0000_0022);
    pulse_en;
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h0000_0022;
    tick;
    prog_we = 1'b0;
    wait_valid("coll_wait", n);
    accept("coll_old", 1'b1);
    pc_load = 1'b1; pc_load_val = 6'd0;
    tick;
    pc_load = 1'b0;
    wait_valid("coll_new_wait", n);
    check_word("coll_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
